// File: rtl/calc_pkg.sv
// Shared constants for the calculation post-processing path.
// Lane geometry and saturation bounds used by the datapath.
package calc_pkg;
   localparam int LANES     = 16;
   localparam int BITWIDTH  = 32;
   localparam int OUT_W     = 16;
   localparam int PACK_W    = 2 * OUT_W * LANES;

   localparam int SAT32_MAX = 32'h7FFF_FFFF;
   localparam int SAT32_MIN = 32'h8000_0000;
   localparam int SAT16_MAX = 32767;
   localparam int SAT16_MIN = -32768;
endpackage

// File: rtl/post_proc_lane.sv
// One lane of the post-processing datapath.
// S1: bias add with 32-bit saturation; S2: round shift, ReLU, 16-bit saturation.
module post_proc_lane
   import calc_pkg::*;
(
   input  logic                       clk_calc,
   input  logic                       rst,
   input  logic                       s0_vld,
   input  logic                       s1_vld,
   input  logic signed [BITWIDTH-1:0] data,
   input  logic signed [BITWIDTH-1:0] bias,
   input  logic [4:0]                 shift,
   input  logic                       relu_en,
   output logic signed [OUT_W-1:0]    y
);

   localparam int XW = BITWIDTH + 1;

   logic signed [XW-1:0]       sum;
   logic signed [BITWIDTH-1:0] sum_sat;
   logic signed [BITWIDTH-1:0] s1_q;
   logic signed [XW-1:0]       xe;
   logic signed [XW-1:0]       rnd;
   logic signed [XW-1:0]       shf;
   logic signed [XW-1:0]       rel;
   logic signed [OUT_W-1:0]    y_sat;

   // Bias add in 33 bits, then clamp back into the 32-bit range
   always_comb begin
      sum = {data[BITWIDTH-1], data} + {bias[BITWIDTH-1], bias};
      if (sum > XW'(SAT32_MAX))
         sum_sat = BITWIDTH'(SAT32_MAX);
      else if (sum < XW'(SAT32_MIN))
         sum_sat = BITWIDTH'(SAT32_MIN);
      else
         sum_sat = sum[BITWIDTH-1:0];
   end

   // Round-half-up shift (rounding constant is zero when shift is 0),
   // optional ReLU, then clamp to the 16-bit output range
   always_comb begin
      xe = {s1_q[BITWIDTH-1], s1_q};
      if (shift == 5'd0)
         rnd = '0;
      else
         rnd = XW'(1) <<< (shift - 5'd1);
      shf = (xe + rnd) >>> shift;
      if (relu_en && shf[XW-1])
         rel = '0;
      else
         rel = shf;
      if (rel > XW'(SAT16_MAX))
         y_sat = OUT_W'(SAT16_MAX);
      else if (rel < XW'(SAT16_MIN))
         y_sat = OUT_W'(SAT16_MIN);
      else
         y_sat = rel[OUT_W-1:0];
   end

   // Stage registers advance only when their input stage holds a vector
   always_ff @(posedge clk_calc or posedge rst) begin
      if (rst) begin
         s1_q <= '0;
         y    <= '0;
      end else begin
         if (s0_vld)
            s1_q <= sum_sat;
         if (s1_vld)
            y <= y_sat;
      end
   end

endmodule

// File: rtl/calc_post_proc.sv
// Post-processing stage behind the 16-lane calculation unit:
// per-lane bias/shift/ReLU/saturate, pairwise packing, show-ahead FIFO.
module calc_post_proc
   import calc_pkg::*;
#(
   parameter int BITWIDTH   = calc_pkg::BITWIDTH,
   parameter int LANES      = calc_pkg::LANES,
   parameter int OUT_W      = calc_pkg::OUT_W,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                      clk_calc,
   input  logic                      rst,
   input  logic                      cfg_load,
   input  logic [BITWIDTH*LANES-1:0] bias_in,
   input  logic [4:0]                shift_in,
   input  logic                      relu_en_in,
   input  logic                      data_in_vld,
   input  logic [BITWIDTH*LANES-1:0] data_in,
   input  logic                      flush,
   output logic                      out_vld,
   input  logic                      out_rdy,
   output logic [2*OUT_W*LANES-1:0]  out_data,
   output logic                      busy,
   output logic                      overflow
);

   localparam int HALF_W = OUT_W * LANES;
   localparam int WORD_W = 2 * HALF_W;
   localparam int AW     = $clog2(FIFO_DEPTH);

   logic [BITWIDTH*LANES-1:0] bias_q;
   logic [4:0]                shift_q;
   logic                      relu_q;

   logic                      s0_vld;
   logic [BITWIDTH*LANES-1:0] s0_data;
   logic                      s1_vld;
   logic                      s2_vld;
   logic [HALF_W-1:0]         s2_vec;

   logic                      phase;
   logic [HALF_W-1:0]         held;
   logic                      flush_pend;

   logic [WORD_W-1:0]         mem [FIFO_DEPTH];
   logic [AW-1:0]             wptr;
   logic [AW-1:0]             rptr;
   logic [AW:0]               count;

   logic                      pipe_empty;
   logic                      flush_fire;
   logic                      flush_drop;
   logic                      push;
   logic [WORD_W-1:0]         push_word;
   logic                      full;
   logic                      empty;
   logic                      pop;
   logic                      wr_en;
   logic                      cfg_take;

   genvar gi;
   generate
      for (gi = 0; gi < LANES; gi++) begin : g_lane
         post_proc_lane u_lane (
            .clk_calc (clk_calc),
            .rst      (rst),
            .s0_vld   (s0_vld),
            .s1_vld   (s1_vld),
            .data     (s0_data[gi*BITWIDTH +: BITWIDTH]),
            .bias     (bias_q[gi*BITWIDTH +: BITWIDTH]),
            .shift    (shift_q),
            .relu_en  (relu_q),
            .y        (s2_vec[gi*OUT_W +: OUT_W])
         );
      end
   endgenerate

   assign pipe_empty = !s0_vld && !s1_vld && !s2_vld;
   assign flush_fire = flush_pend && phase && pipe_empty;
   assign flush_drop = flush_pend && !phase && pipe_empty;
   assign push       = (s2_vld && phase) || flush_fire;
   assign push_word  = s2_vld ? {s2_vec, held}
                              : {{HALF_W{1'b0}}, held};

   assign empty    = (count == '0);
   assign full     = (count == (AW+1)'(FIFO_DEPTH));
   assign pop      = !empty && out_rdy;
   assign wr_en    = push && (!full || pop);
   assign out_vld  = !empty;
   assign out_data = empty ? '0 : mem[rptr];

   assign busy     = !pipe_empty || phase || flush_pend || !empty;
   assign cfg_take = cfg_load && !busy;

   // Configuration only changes when nothing is in flight
   always_ff @(posedge clk_calc or posedge rst) begin
      if (rst) begin
         bias_q  <= '0;
         shift_q <= '0;
         relu_q  <= 1'b0;
      end else if (cfg_take) begin
         bias_q  <= bias_in;
         shift_q <= shift_in;
         relu_q  <= relu_en_in;
      end
   end

   // Sticky drop flag, cleared by an accepted configuration load
   always_ff @(posedge clk_calc or posedge rst) begin
      if (rst)
         overflow <= 1'b0;
      else if (cfg_take)
         overflow <= 1'b0;
      else if (push && !wr_en)
         overflow <= 1'b1;
   end

   // Input capture and stage valid chain
   always_ff @(posedge clk_calc or posedge rst) begin
      if (rst) begin
         s0_vld  <= 1'b0;
         s0_data <= '0;
         s1_vld  <= 1'b0;
         s2_vld  <= 1'b0;
      end else begin
         s0_vld <= data_in_vld;
         if (data_in_vld)
            s0_data <= data_in;
         s1_vld <= s0_vld;
         s2_vld <= s1_vld;
      end
   end

   // Pairing of vectors and flush of a lone held half
   always_ff @(posedge clk_calc or posedge rst) begin
      if (rst) begin
         phase      <= 1'b0;
         held       <= '0;
         flush_pend <= 1'b0;
      end else begin
         if (s2_vld) begin
            if (!phase) begin
               held  <= s2_vec;
               phase <= 1'b1;
            end else begin
               phase <= 1'b0;
            end
         end else if (flush_fire) begin
            phase <= 1'b0;
         end
         if (flush)
            flush_pend <= 1'b1;
         else if (flush_fire || flush_drop)
            flush_pend <= 1'b0;
      end
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk_calc or posedge rst) begin
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (wr_en)
            wptr <= wptr + 1'b1;
         if (pop)
            rptr <= rptr + 1'b1;
         case ({wr_en, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // FIFO storage; contents are masked by empty so no reset is needed
   always_ff @(posedge clk_calc) begin
      if (wr_en)
         mem[wptr] <= push_word;
   end

endmodule

// File: tb/tb_calc_post_proc.sv
// Directed bench for calc_post_proc.
// Hand-computed vectors for packing, rounding, ReLU, overflow, flush, reset.
module tb_calc_post_proc;
   import calc_pkg::*;

   logic                 clk_calc = 1'b0;
   logic                 rst;
   logic                 cfg_load;
   logic [511:0]         bias_in;
   logic [4:0]           shift_in;
   logic                 relu_en_in;
   logic                 data_in_vld;
   logic [511:0]         data_in;
   logic                 flush;
   logic                 out_vld;
   logic                 out_rdy;
   logic [511:0]         out_data;
   logic                 busy;
   logic                 overflow;

   int n_chk = 0;
   int n_err = 0;

   calc_post_proc dut (
      .clk_calc    (clk_calc),
      .rst         (rst),
      .cfg_load    (cfg_load),
      .bias_in     (bias_in),
      .shift_in    (shift_in),
      .relu_en_in  (relu_en_in),
      .data_in_vld (data_in_vld),
      .data_in     (data_in),
      .flush       (flush),
      .out_vld     (out_vld),
      .out_rdy     (out_rdy),
      .out_data    (out_data),
      .busy        (busy),
      .overflow    (overflow)
   );

   always #5 clk_calc = ~clk_calc;

   task automatic check(input string tag, input logic [511:0] got,
                        input logic [511:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h exp %h", tag, got, exp);
      end
   endtask

   function automatic logic [511:0] fill32(input logic [31:0] v);
      logic [511:0] r;
      for (int i = 0; i < 16; i++) r[i*32 +: 32] = v;
      return r;
   endfunction

   function automatic logic [255:0] fill16(input logic [15:0] v);
      logic [255:0] r;
      for (int i = 0; i < 16; i++) r[i*16 +: 16] = v;
      return r;
   endfunction

   task automatic tick();
      @(posedge clk_calc);
      #1;
   endtask

   task automatic cfg(input logic [511:0] b, input logic [4:0] s,
                      input logic r);
      bias_in    = b;
      shift_in   = s;
      relu_en_in = r;
      cfg_load   = 1'b1;
      tick();
      cfg_load   = 1'b0;
   endtask

   task automatic send(input logic [511:0] v);
      data_in     = v;
      data_in_vld = 1'b1;
      tick();
      data_in_vld = 1'b0;
   endtask

   task automatic pop1();
      out_rdy = 1'b1;
      tick();
      out_rdy = 1'b0;
   endtask

   task automatic wait_vld(input int max);
      int k;
      k = 0;
      while (!out_vld && k < max) begin
         tick();
         k++;
      end
      check("vld_wait", 512'(out_vld), 512'(1));
   endtask

   initial begin
      logic [511:0] d;
      logic [255:0] lo;

      rst         = 1'b1;
      cfg_load    = 1'b0;
      bias_in     = '0;
      shift_in    = '0;
      relu_en_in  = 1'b0;
      data_in_vld = 1'b0;
      data_in     = '0;
      flush       = 1'b0;
      out_rdy     = 1'b0;
      tick();
      tick();
      check("rst_vld",  512'(out_vld),  512'(0));
      check("rst_busy", 512'(busy),     512'(0));
      check("rst_ovf",  512'(overflow), 512'(0));
      check("rst_data", out_data,       '0);
      rst = 1'b0;
      tick();

      // Basic pairing and latency
      cfg('0, 5'd0, 1'b0);
      send(fill32(32'd5));
      send(fill32(-32'sd7));
      tick();
      check("lat_n1", 512'(out_vld), 512'(0));
      tick();
      check("lat_n2", 512'(out_vld), 512'(0));
      tick();
      check("lat_n3", 512'(out_vld), 512'(1));
      check("pair_ab", out_data, {fill16(16'hFFF9), fill16(16'h0005)});
      pop1();
      check("pop_vld",  512'(out_vld), 512'(0));
      check("pop_busy", 512'(busy),    512'(0));

      // Bias saturation and rounding shift
      cfg(fill32(32'h100), 5'd16, 1'b0);
      send(fill32(32'h7FFF_FFF0));
      send(fill32(32'h0001_0000));
      wait_vld(10);
      check("sat_rnd", out_data, {fill16(16'h0001), fill16(16'h7FFF)});
      pop1();
      cfg('0, 5'd1, 1'b0);
      send(fill32(-32'sd3));
      send(fill32(32'd3));
      wait_vld(10);
      check("rnd_half", out_data, {fill16(16'h0002), fill16(16'hFFFF)});
      pop1();

      // ReLU and 16-bit saturation
      cfg('0, 5'd0, 1'b1);
      d = '0;
      d[31:0]  = -32'sd1000;
      d[63:32] = 32'd1000;
      d[95:64] = 32'd70000;
      send(d);
      send(fill32(-32'sd5));
      wait_vld(10);
      lo = '0;
      lo[15:0]  = 16'h0000;
      lo[31:16] = 16'h03E8;
      lo[47:32] = 16'h7FFF;
      check("relu", out_data, {256'b0, lo});
      pop1();

      // Overflow: 10 vectors back-to-back with consumer stalled
      cfg('0, 5'd0, 1'b0);
      for (int k = 0; k < 10; k++) begin
         data_in     = fill32(32'(k + 1));
         data_in_vld = 1'b1;
         tick();
      end
      data_in_vld = 1'b0;
      for (int k = 0; k < 4; k++) tick();
      check("ovf_set", 512'(overflow), 512'(1));
      check("ovf_vld", 512'(out_vld),  512'(1));
      out_rdy = 1'b1;
      for (int w = 0; w < 4; w++) begin
         check($sformatf("ovf_w%0d", w), out_data,
               {fill16(16'(2*w + 2)), fill16(16'(2*w + 1))});
         tick();
      end
      out_rdy = 1'b0;
      check("ovf_drained", 512'(out_vld), 512'(0));
      check("ovf_idle",    512'(busy),    512'(0));
      check("ovf_sticky",  512'(overflow), 512'(1));
      cfg('0, 5'd0, 1'b0);
      check("ovf_clr", 512'(overflow), 512'(0));

      // Flush of a lone vector
      send(fill32(32'd9));
      tick();
      tick();
      tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("fl_n0", 512'(out_vld), 512'(0));
      tick();
      check("fl_n1", 512'(out_vld), 512'(1));
      check("fl_word", out_data, {256'b0, fill16(16'h0009)});
      check("fl_busy", 512'(busy), 512'(1));
      pop1();
      check("fl_idle", 512'(busy), 512'(0));

      // Configuration load while busy is ignored
      send(fill32(32'd64));
      cfg('0, 5'd4, 1'b0);
      send(fill32(32'd64));
      wait_vld(10);
      check("cfg_busy", out_data, {fill16(16'd64), fill16(16'd64)});
      pop1();

      // Reset in the middle of a pair
      send(fill32(32'd1));
      send(fill32(32'd2));
      send(fill32(32'd3));
      for (int k = 0; k < 4; k++) tick();
      check("pre_rst_vld", 512'(out_vld), 512'(1));
      rst = 1'b1;
      #1;
      check("rst_mid_vld",  512'(out_vld), 512'(0));
      check("rst_mid_busy", 512'(busy),    512'(0));
      tick();
      rst = 1'b0;
      tick();
      send(fill32(32'd4));
      send(fill32(32'd5));
      wait_vld(10);
      check("post_rst", out_data, {fill16(16'd5), fill16(16'd4)});
      pop1();
      check("post_rst_idle", 512'(busy), 512'(0));

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
